// File: rtl/dual_port_mem_pipelined.sv
// dual_port_mem_pipelined
//   Two-port (A/B) byte-enabled behavioural SRAM for e-GPU local/shared memory.
//   Each port takes a valid/ready request and returns read data through a READ_LAT-deep
//   pipeline. After reset an init FSM clears two words per cycle, so the array itself
//   needs no reset fan-out. Requests are only accepted once the clear is complete.
//
// Parameters
//   DATAW    word width in bits (multiple of 8)
//   SIZE     number of words (>= 2)
//   BYTEENW  byte-enable width; 1 means whole-word writes
//   READ_LAT read latency in cycles, 1..4
//   ADDRW    address width, derived from SIZE
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            synchronous active-high reset
//   init_done_o      high once the array clear has finished
//   x_req_valid_i    request valid (x = a or b)
//   x_req_ready_o    request ready, equal to init_done_o
//   x_addr_i         word address
//   x_wren_i         byte write enables; all zero means read
//   x_wdata_i        write data
//   x_rsp_valid_o    read response valid, one cycle, READ_LAT cycles after accept
//   x_rdata_o        read data, holds its last value while x_rsp_valid_o is low
//
// Configuration
//   E_GPU_MEM_FWD_EN  when defined, a read that collides with a same-cycle write to the
//                     same address returns the newly written bytes (write-first).
//                     When undefined the read returns the old contents (read-first).

module dual_port_mem_pipelined #(
  parameter int unsigned DATAW    = 32,
  parameter int unsigned SIZE     = 1024,
  parameter int unsigned BYTEENW  = DATAW / 8,
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned ADDRW    = $clog2(SIZE)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic               init_done_o,

  input  logic               a_req_valid_i,
  output logic               a_req_ready_o,
  input  logic [ADDRW-1:0]   a_addr_i,
  input  logic [BYTEENW-1:0] a_wren_i,
  input  logic [DATAW-1:0]   a_wdata_i,
  output logic               a_rsp_valid_o,
  output logic [DATAW-1:0]   a_rdata_o,

  input  logic               b_req_valid_i,
  output logic               b_req_ready_o,
  input  logic [ADDRW-1:0]   b_addr_i,
  input  logic [BYTEENW-1:0] b_wren_i,
  input  logic [DATAW-1:0]   b_wdata_i,
  output logic               b_rsp_valid_o,
  output logic [DATAW-1:0]   b_rdata_o
);

  localparam int unsigned LaneW = DATAW / BYTEENW;
  // One extra bit so the init counter can step past the last word without wrapping.
  localparam int unsigned CntW  = ADDRW + 1;

  typedef enum logic {StInit, StReady} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [DATAW-1:0] mem [SIZE];

  logic             ready;
  logic [ADDRW-1:0] init_idx0, init_idx1;
  logic             init_two;

  logic             a_in_range, b_in_range;
  logic             a_acc, b_acc;
  logic             a_rd_acc, b_rd_acc;
  logic             a_we, b_we;
  logic [DATAW-1:0] a_rd_data, b_rd_data;

  logic [READ_LAT-1:0]            a_vld_q, b_vld_q;
  logic [READ_LAT-1:0][DATAW-1:0] a_dat_q, b_dat_q;

  // ---------------------------------------------------------------------------------------
  // Init FSM: clears words cnt and cnt+1 each cycle, then stays in StReady until reset.
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StInit: begin
        cnt_d = cnt_q + CntW'(2);
        // Leave once this cycle's pair covers the last word (odd SIZE clears one word).
        if (32'(cnt_q) + 32'd2 >= SIZE) begin
          state_d = StReady;
        end
      end
      StReady: state_d = StReady;
      default: state_d = StInit;
    endcase
  end

  assign ready         = (state_q == StReady);
  assign init_done_o   = ready;
  assign a_req_ready_o = ready;
  assign b_req_ready_o = ready;

  assign init_idx0 = cnt_q[ADDRW-1:0];
  assign init_idx1 = init_idx0 + ADDRW'(1);
  assign init_two  = (32'(cnt_q) + 32'd1 < SIZE);

  // ---------------------------------------------------------------------------------------
  // Request decode. Out-of-range addresses only exist when SIZE is not a power of two.
  // ---------------------------------------------------------------------------------------
  if (SIZE == (32'd1 << ADDRW)) begin : g_pow2
    assign a_in_range = 1'b1;
    assign b_in_range = 1'b1;
  end else begin : g_npow2
    assign a_in_range = (32'(a_addr_i) < SIZE);
    assign b_in_range = (32'(b_addr_i) < SIZE);
  end

  // A request on the reset edge is discarded.
  assign a_acc    = a_req_valid_i & ready & ~rst_i;
  assign b_acc    = b_req_valid_i & ready & ~rst_i;
  assign a_rd_acc = a_acc & (a_wren_i == '0);
  assign b_rd_acc = b_acc & (b_wren_i == '0);
  assign a_we     = a_acc & (|a_wren_i) & a_in_range;
  assign b_we     = b_acc & (|b_wren_i) & b_in_range;

  // ---------------------------------------------------------------------------------------
  // Array write: init clear, then B lanes, then A lanes so A wins on a shared byte.
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_i && (state_q == StInit)) begin
      mem[init_idx0] <= '0;
      if (init_two) begin
        mem[init_idx1] <= '0;
      end
    end
    for (int k = 0; k < BYTEENW; k++) begin
      if (b_we && b_wren_i[k]) begin
        mem[b_addr_i][k*LaneW +: LaneW] <= b_wdata_i[k*LaneW +: LaneW];
      end
      if (a_we && a_wren_i[k]) begin
        mem[a_addr_i][k*LaneW +: LaneW] <= a_wdata_i[k*LaneW +: LaneW];
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Array read. A reading port is not writing, so with forwarding only the other port's
  // write can overlay the old word; the A-over-B merge therefore reduces to that overlay.
  // ---------------------------------------------------------------------------------------
  always_comb begin
    a_rd_data = '0;
    if (a_in_range) begin
      a_rd_data = mem[a_addr_i];
    end
`ifdef E_GPU_MEM_FWD_EN
    for (int k = 0; k < BYTEENW; k++) begin
      if (b_we && b_wren_i[k] && (b_addr_i == a_addr_i)) begin
        a_rd_data[k*LaneW +: LaneW] = b_wdata_i[k*LaneW +: LaneW];
      end
    end
`endif
  end

  always_comb begin
    b_rd_data = '0;
    if (b_in_range) begin
      b_rd_data = mem[b_addr_i];
    end
`ifdef E_GPU_MEM_FWD_EN
    for (int k = 0; k < BYTEENW; k++) begin
      if (a_we && a_wren_i[k] && (a_addr_i == b_addr_i)) begin
        b_rd_data[k*LaneW +: LaneW] = a_wdata_i[k*LaneW +: LaneW];
      end
    end
`endif
  end

  // ---------------------------------------------------------------------------------------
  // Response pipelines. A data stage only loads when the stage before it is valid, so the
  // last stage (the output) holds the previous response between reads.
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_vld_q <= '0;
      a_dat_q <= '0;
    end else begin
      a_vld_q[0] <= a_rd_acc;
      if (a_rd_acc) begin
        a_dat_q[0] <= a_rd_data;
      end
      for (int i = 1; i < READ_LAT; i++) begin
        a_vld_q[i] <= a_vld_q[i-1];
        if (a_vld_q[i-1]) begin
          a_dat_q[i] <= a_dat_q[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      b_vld_q <= '0;
      b_dat_q <= '0;
    end else begin
      b_vld_q[0] <= b_rd_acc;
      if (b_rd_acc) begin
        b_dat_q[0] <= b_rd_data;
      end
      for (int i = 1; i < READ_LAT; i++) begin
        b_vld_q[i] <= b_vld_q[i-1];
        if (b_vld_q[i-1]) begin
          b_dat_q[i] <= b_dat_q[i-1];
        end
      end
    end
  end

  assign a_rsp_valid_o = a_vld_q[READ_LAT-1];
  assign a_rdata_o     = a_dat_q[READ_LAT-1];
  assign b_rsp_valid_o = b_vld_q[READ_LAT-1];
  assign b_rdata_o     = b_dat_q[READ_LAT-1];

endmodule

// File: tb/tb_dual_port_mem_pipelined.sv
// Self-checking bench for dual_port_mem_pipelined (SIZE=13 so the odd-size init and
// out-of-range addresses are exercised, READ_LAT=3). A behavioural model holds the
// word array, init progress and per-port queues of expected responses with due cycles.
module tb_dual_port_mem_pipelined;
  localparam int unsigned DATAW    = 32;
  localparam int unsigned SIZE     = 13;
  localparam int unsigned BYTEENW  = 4;
  localparam int unsigned READ_LAT = 3;
  localparam int unsigned ADDRW    = 4;
  localparam int unsigned INIT_CYC = (SIZE + 1) / 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               init_done;
  logic               a_valid, a_ready, a_rsp_valid;
  logic [ADDRW-1:0]   a_addr;
  logic [BYTEENW-1:0] a_wren;
  logic [DATAW-1:0]   a_wdata, a_rdata;
  logic               b_valid, b_ready, b_rsp_valid;
  logic [ADDRW-1:0]   b_addr;
  logic [BYTEENW-1:0] b_wren;
  logic [DATAW-1:0]   b_wdata, b_rdata;

  always #5 clk = ~clk;

  dual_port_mem_pipelined #(
    .DATAW(DATAW), .SIZE(SIZE), .BYTEENW(BYTEENW), .READ_LAT(READ_LAT), .ADDRW(ADDRW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .init_done_o(init_done),
    .a_req_valid_i(a_valid), .a_req_ready_o(a_ready), .a_addr_i(a_addr),
    .a_wren_i(a_wren), .a_wdata_i(a_wdata), .a_rsp_valid_o(a_rsp_valid), .a_rdata_o(a_rdata),
    .b_req_valid_i(b_valid), .b_req_ready_o(b_ready), .b_addr_i(b_addr),
    .b_wren_i(b_wren), .b_wdata_i(b_wdata), .b_rsp_valid_o(b_rsp_valid), .b_rdata_o(b_rdata)
  );

  int tot = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model
  typedef struct { int due; logic [31:0] data; } rsp_t;
  logic [31:0] model [SIZE];
  logic        m_ready = 1'b0;
  int          m_init  = 0;
  rsp_t        qa[$];
  rsp_t        qb[$];
  logic        ea_v = 1'b0, eb_v = 1'b0;
  logic [31:0] ea_d = '0, eb_d = '0;

  function automatic logic [31:0] peek(input logic [3:0] addr, input logic ow,
                                       input logic [3:0] oaddr, input logic [3:0] owren,
                                       input logic [31:0] owdata);
    logic [31:0] v;
    v = (32'(addr) < SIZE) ? model[addr] : 32'h0;
`ifdef E_GPU_MEM_FWD_EN
    if (ow && oaddr == addr)
      for (int k = 0; k < 4; k++) if (owren[k]) v[8*k +: 8] = owdata[8*k +: 8];
`endif
    return v;
  endfunction

  // Advance one clock edge, update the model with the inputs sampled there, then settle.
  task automatic step();
    logic a_w, b_w;
    rsp_t r;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_ready = 1'b0; m_init = 0;
      qa.delete(); qb.delete();
      ea_d = '0; eb_d = '0;
    end else if (!m_ready) begin
      m_init++;
      if (m_init == int'(INIT_CYC)) begin
        m_ready = 1'b1;
        for (int i = 0; i < int'(SIZE); i++) model[i] = '0;
      end
    end else begin
      a_w = a_valid && a_wren != 0 && 32'(a_addr) < SIZE;
      b_w = b_valid && b_wren != 0 && 32'(b_addr) < SIZE;
      if (a_valid && a_wren == 0) begin
        r.due = cyc + int'(READ_LAT) - 1;
        r.data = peek(a_addr, b_w, b_addr, b_wren, b_wdata);
        qa.push_back(r);
      end
      if (b_valid && b_wren == 0) begin
        r.due = cyc + int'(READ_LAT) - 1;
        r.data = peek(b_addr, a_w, a_addr, a_wren, a_wdata);
        qb.push_back(r);
      end
      for (int k = 0; k < 4; k++) begin
        if (b_w && b_wren[k]) model[b_addr][8*k +: 8] = b_wdata[8*k +: 8];
        if (a_w && a_wren[k]) model[a_addr][8*k +: 8] = a_wdata[8*k +: 8];
      end
    end
    ea_v = 1'b0; eb_v = 1'b0;
    if (qa.size() > 0 && qa[0].due == cyc) begin ea_v = 1'b1; ea_d = qa[0].data; qa.delete(0); end
    if (qb.size() > 0 && qb[0].due == cyc) begin eb_v = 1'b1; eb_d = qb[0].data; qb.delete(0); end
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [3:0] ad, input logic [3:0] we,
                         input logic [31:0] wd);
    a_valid = v; a_addr = ad; a_wren = we; a_wdata = wd;
  endtask

  task automatic drive_b(input logic v, input logic [3:0] ad, input logic [3:0] we,
                         input logic [31:0] wd);
    b_valid = v; b_addr = ad; b_wren = we; b_wdata = wd;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    drive_a(0, 0, 0, 0); drive_b(0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      tot++;
      if (init_done !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0 || a_rsp_valid !== 1'b0 ||
          b_rsp_valid !== 1'b0 || a_rdata !== 32'h0 || b_rdata !== 32'h0) begin
        bad++;
        $display("FAIL reset_state: got done=%b rdy=%b%b vld=%b%b rd=%h/%h want all 0",
                 init_done, a_ready, b_ready, a_rsp_valid, b_rsp_valid, a_rdata, b_rdata);
      end
    end
    rst = 1'b0;
    n = 0;
    // Writes presented during init must be ignored.
    drive_a(1, 3, 4'hF, 32'hFFFF_FFFF);
    while (init_done !== 1'b1 && n < 50) begin
      step();
      n++;
      tot++;
      if (init_done !== m_ready || a_ready !== m_ready || b_ready !== m_ready) begin
        bad++;
        $display("FAIL init_ready: cycle %0d got done=%b rdy=%b%b want %b",
                 n, init_done, a_ready, b_ready, m_ready);
      end
    end
    drive_a(0, 0, 0, 0);
    tot++;
    if (n != int'(INIT_CYC)) begin
      bad++;
      $display("FAIL init_length: got %0d cycles want %0d", n, INIT_CYC);
    end
    for (int c = 0; c < int'(SIZE + READ_LAT); c++) begin
      if (c < int'(SIZE)) begin
        drive_a(1, 4'(c), 0, 0);
        drive_b(1, 4'(int'(SIZE) - 1 - c), 0, 0);
      end else begin
        drive_a(0, 0, 0, 0); drive_b(0, 0, 0, 0);
      end
      step();
      tot++;
      if (a_rsp_valid !== ea_v || b_rsp_valid !== eb_v) begin
        bad++;
        $display("FAIL read_all_valid: got %b%b want %b%b", a_rsp_valid, b_rsp_valid, ea_v, eb_v);
      end
      tot++;
      if (a_rdata !== ea_d || b_rdata !== eb_d) begin
        bad++;
        $display("FAIL read_all_data: got %h/%h want %h/%h", a_rdata, b_rdata, ea_d, eb_d);
      end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] got;
    got = '0;
    for (int c = 0; c < int'(READ_LAT) + 3; c++) begin
      drive_a(c < 2, 5, (c == 0) ? 4'b0001 : 4'b0000, 32'h0000_00AA);
      step();
      if (a_rsp_valid === 1'b1) got = a_rdata;
      tot++;
      if (a_rsp_valid !== ea_v || a_rdata !== ea_d) begin
        bad++;
        $display("FAIL write_read: got v=%b d=%h want v=%b d=%h", a_rsp_valid, a_rdata, ea_v, ea_d);
      end
    end
    tot++;
    if (got !== 32'h0000_00AA) begin
      bad++;
      $display("FAIL write_read_word5: got %h want 000000aa", got);
    end
  endtask

  task automatic test_back_to_back();
    int first, cnt;
    first = -1; cnt = 0;
    for (int c = 0; c < 8; c++) begin
      drive_b(1, 4'(c), 4'hF, $urandom);
      step();
    end
    drive_b(0, 0, 0, 0);
    for (int c = 0; c < 8 + int'(READ_LAT) + 2; c++) begin
      drive_a(c < 8, 4'(c), 0, 0);
      step();
      if (a_rsp_valid === 1'b1) begin
        cnt++;
        if (first < 0) first = c;
      end
      tot++;
      if (a_rsp_valid !== ea_v || a_rdata !== ea_d) begin
        bad++;
        $display("FAIL back_to_back: cycle %0d got v=%b d=%h want v=%b d=%h",
                 c, a_rsp_valid, a_rdata, ea_v, ea_d);
      end
    end
    tot++;
    if (first != int'(READ_LAT) - 1 || cnt != 8) begin
      bad++;
      $display("FAIL back_to_back_timing: got first=%0d count=%0d want first=%0d count=8",
               first, cnt, READ_LAT - 1);
    end
  endtask

  task automatic test_write_collision();
    logic [31:0] got;
    got = '0;
    drive_a(1, 9, 4'b1100, 32'h1111_1111);
    drive_b(1, 9, 4'b0110, 32'h2222_2222);
    step();
    drive_b(0, 0, 0, 0);
    for (int c = 0; c < int'(READ_LAT) + 2; c++) begin
      drive_a(c == 0, 9, 0, 0);
      step();
      if (a_rsp_valid === 1'b1) got = a_rdata;
      tot++;
      if (a_rsp_valid !== ea_v || a_rdata !== ea_d) begin
        bad++;
        $display("FAIL ww_collision: got v=%b d=%h want v=%b d=%h", a_rsp_valid, a_rdata, ea_v, ea_d);
      end
    end
    tot++;
    if (got !== 32'h1111_2200) begin
      bad++;
      $display("FAIL ww_collision_word9: got %h want 11112200", got);
    end
  endtask

  task automatic test_rw_collision();
    logic [31:0] got, want;
`ifdef E_GPU_MEM_FWD_EN
    want = 32'h0;
`else
    want = 32'hDEAD_BEEF;
`endif
    got = 32'h1234_5678;
    drive_a(1, 4, 4'hF, 32'hDEAD_BEEF);
    step();
    drive_a(1, 4, 4'hF, 32'h0);
    drive_b(1, 4, 0, 0);
    step();
    if (b_rsp_valid === 1'b1) got = b_rdata;
    drive_a(0, 0, 0, 0); drive_b(0, 0, 0, 0);
    for (int c = 0; c < int'(READ_LAT) + 1; c++) begin
      step();
      if (b_rsp_valid === 1'b1) got = b_rdata;
      tot++;
      if (b_rsp_valid !== eb_v || b_rdata !== eb_d) begin
        bad++;
        $display("FAIL rw_collision: got v=%b d=%h want v=%b d=%h", b_rsp_valid, b_rdata, eb_v, eb_d);
      end
    end
    tot++;
    if (got !== want) begin
      bad++;
      $display("FAIL rw_collision_word4: got %h want %h", got, want);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive_a($urandom_range(0, 4) != 0,
              4'($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 15)),
              4'($urandom_range(0, 1) ? 0 : $urandom_range(0, 15)), $urandom);
      drive_b($urandom_range(0, 4) != 0,
              4'($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 15)),
              4'($urandom_range(0, 1) ? 0 : $urandom_range(0, 15)), $urandom);
      step();
      tot++;
      if (a_rsp_valid !== ea_v || b_rsp_valid !== eb_v) begin
        bad++;
        $display("FAIL random_valid: cycle %0d got %b%b want %b%b",
                 c, a_rsp_valid, b_rsp_valid, ea_v, eb_v);
      end
      tot++;
      if (a_rdata !== ea_d || b_rdata !== eb_d) begin
        bad++;
        $display("FAIL random_data: cycle %0d got %h/%h want %h/%h", c, a_rdata, b_rdata, ea_d, eb_d);
      end
    end
    drive_a(0, 0, 0, 0); drive_b(0, 0, 0, 0);
    for (int c = 0; c < int'(READ_LAT); c++) step();
  endtask

  task automatic test_reset_midflight();
    int n, nrsp;
    n = 0; nrsp = 0;
    for (int c = 0; c < 2; c++) begin
      drive_a(1, 4'(c + 4), 0, 0);
      drive_b(1, 9, 0, 0);
      step();
    end
    drive_a(0, 0, 0, 0); drive_b(0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    if (a_rsp_valid !== 1'b0 || b_rsp_valid !== 1'b0) nrsp++;
    tot++;
    if (a_rdata !== 32'h0 || b_rdata !== 32'h0 || init_done !== 1'b0) begin
      bad++;
      $display("FAIL midflight_reset_state: got rd=%h/%h done=%b want 0/0/0",
               a_rdata, b_rdata, init_done);
    end
    while (init_done !== 1'b1 && n < 50) begin
      step();
      n++;
      if (a_rsp_valid !== 1'b0 || b_rsp_valid !== 1'b0) nrsp++;
    end
    tot++;
    if (nrsp != 0 || n != int'(INIT_CYC)) begin
      bad++;
      $display("FAIL midflight_reinit: got %0d stray rsp, %0d init cycles want 0, %0d",
               nrsp, n, INIT_CYC);
    end
    for (int c = 0; c < int'(SIZE + READ_LAT); c++) begin
      drive_a(c < int'(SIZE), 4'(c), 0, 0);
      step();
      tot++;
      if (a_rsp_valid !== ea_v || a_rdata !== ea_d) begin
        bad++;
        $display("FAIL midflight_readback: cycle %0d got v=%b d=%h want v=%b d=%h",
                 c, a_rsp_valid, a_rdata, ea_v, ea_d);
      end
    end
    drive_a(0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_write_collision();
    test_rw_collision();
    test_random();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
